// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID pipeline register with a valid/ready handshake,
// a 2-entry skid buffer, a synchronous flush and a synchronous reset.
//
// The main entry drives the outputs directly. The skid entry catches the one
// beat that is accepted while Decode is stalled. Because in_ready depends only
// on a register, there is no combinational path from input to output.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   Fetch offers instr_in/npc_in
//   in_ready   register can take a beat this cycle
//   instr_in   fetched instruction
//   npc_in     PC+4 of the fetched instruction
//   flush      drop every held beat and the incoming one (redirect)
//   out_valid  instr_out/npc_out hold a valid beat
//   out_ready  Decode takes the beat this cycle
//   instr_out  instruction to Decode (NOP_INSTR after reset/flush)
//   npc_out    PC+4 to Decode (0 after reset/flush)
//   stall_cnt  saturating count of out_valid & ~out_ready cycles
//
// Optional feature: define STALL_CNT_EN to add the stall_cnt port and counter.

module if_id_skid_reg #(
  parameter int unsigned         INSTR_W   = 32,
  parameter int unsigned         NPC_W     = 32,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(32'h0000_0000)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [NPC_W-1:0]   npc_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [NPC_W-1:0]   npc_out
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  logic               m_valid_q, m_valid_d;
  logic [INSTR_W-1:0] m_instr_q, m_instr_d;
  logic [NPC_W-1:0]   m_npc_q,   m_npc_d;
  logic               s_valid_q, s_valid_d;
  logic [INSTR_W-1:0] s_instr_q, s_instr_d;
  logic [NPC_W-1:0]   s_npc_q,   s_npc_d;

  logic accept;
  logic consume;

  assign in_ready  = ~s_valid_q;
  assign out_valid = m_valid_q;
  assign instr_out = m_instr_q;
  assign npc_out   = m_npc_q;

  assign accept  = in_valid & ~s_valid_q;
  assign consume = m_valid_q & out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_instr_d = m_instr_q;
    m_npc_d   = m_npc_q;
    s_valid_d = s_valid_q;
    s_instr_d = s_instr_q;
    s_npc_d   = s_npc_q;

    if (flush) begin
      // Skid data is left alone: it is unobservable once s_valid is clear.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_instr_d = NOP_INSTR;
      m_npc_d   = '0;
    end else if (s_valid_q && consume) begin
      // Skid refills main; accept is necessarily 0 here.
      m_instr_d = s_instr_q;
      m_npc_d   = s_npc_q;
      s_valid_d = 1'b0;
    end else if (!m_valid_q && accept) begin
      m_valid_d = 1'b1;
      m_instr_d = instr_in;
      m_npc_d   = npc_in;
    end else if (consume && accept) begin
      m_instr_d = instr_in;
      m_npc_d   = npc_in;
    end else if (consume) begin
      m_valid_d = 1'b0;
    end else if (m_valid_q && !out_ready && accept) begin
      s_valid_d = 1'b1;
      s_instr_d = instr_in;
      s_npc_d   = npc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_instr_q <= NOP_INSTR;
      m_npc_q   <= '0;
      s_valid_q <= 1'b0;
      s_instr_q <= '0;
      s_npc_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_instr_q <= m_instr_d;
      m_npc_q   <= m_npc_d;
      s_valid_q <= s_valid_d;
      s_instr_q <= s_instr_d;
      s_npc_q   <= s_npc_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts through flush cycles too; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Randomized self-checking bench for if_id_skid_reg. The reference model is a
// FIFO of accepted beats (capacity 2) plus the value last shown on the outputs.

module tb_if_id_skid_reg;

  localparam logic [31:0] Nop = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr_in;
  logic [31:0] npc_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic [31:0] npc_out;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  if_id_skid_reg #(
    .INSTR_W   (32),
    .NPC_W     (32),
    .NOP_INSTR (Nop)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr_in  (instr_in),
    .npc_in    (npc_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr_out (instr_out),
    .npc_out   (npc_out)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state.
  logic [63:0] mq[$];          // {instr, npc}, oldest first
  logic [31:0] shown_instr;
  logic [31:0] shown_npc;
  logic [31:0] m_stall;
  logic        last_acc;       // beat offered this cycle was taken

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    int unsigned n;
    last_acc = 1'b0;
    if (!rst_n) begin
      mq.delete();
      shown_instr = Nop;
      shown_npc   = '0;
      m_stall     = '0;
    end else begin
      if (mq.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (flush) begin
        mq.delete();
        shown_instr = Nop;
        shown_npc   = '0;
      end else begin
        n = mq.size();
        if (n > 0 && out_ready) void'(mq.pop_front());
        if (in_valid && n < 2) begin
          mq.push_back({instr_in, npc_in});
          last_acc = 1'b1;
        end
        if (mq.size() > 0) begin
          shown_instr = mq[0][63:32];
          shown_npc   = mq[0][31:0];
        end
      end
    end
  endtask

  task automatic check_all();
    check_eq("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    check_eq("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    check_eq("instr_out", 64'(instr_out), 64'(shown_instr));
    check_eq("npc_out", 64'(npc_out), 64'(shown_npc));
`ifdef STALL_CNT_EN
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  // Apply one cycle of inputs, clock it into DUT and model, then compare.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic rn);
    in_valid  = v;
    instr_in  = ins;
    npc_in    = pc;
    out_ready = ordy;
    flush     = fl;
    rst_n     = rn;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    logic        hold;
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        rn;
    logic [31:0] next_pc;

    in_valid = 1'b0; instr_in = '0; npc_in = '0;
    out_ready = 1'b0; flush = 1'b0; rst_n = 1'b0;
    shown_instr = Nop; shown_npc = '0; m_stall = '0; last_acc = 1'b0;

    // Reset state.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_instr", 64'(instr_out), 64'(Nop));

    // Single beat, one-cycle latency.
    step(1, 32'h2008_0005, 32'h4, 1, 0, 1);
    check_eq("first_valid", 64'(out_valid), 64'd1);
    check_eq("first_instr", 64'(instr_out), 64'h2008_0005);
    check_eq("first_npc", 64'(npc_out), 64'h4);
    check_eq("first_in_ready", 64'(in_ready), 64'd1);
    step(0, 0, 0, 1, 0, 1);

    // Back-to-back stream with out_ready high.
    for (int i = 1; i <= 4; i++) begin
      step(1, 32'h1000_0000 + 32'(i), 32'(4 * i), 1, 0, 1);
      check_eq("stream_npc", 64'(npc_out), 64'(4 * i));
    end
    step(0, 0, 0, 1, 0, 1);
    check_eq("stream_drained", 64'(out_valid), 64'd0);

    // Back-pressure into the skid, then release in order.
    step(1, 32'hA, 32'h4, 0, 0, 1);
    step(1, 32'hB, 32'h8, 0, 0, 1);
    check_eq("skid_in_ready", 64'(in_ready), 64'd0);
    step(1, 32'hC, 32'hC, 0, 0, 1);
    check_eq("skid_hold_npc", 64'(npc_out), 64'h4);
    step(1, 32'hC, 32'hC, 1, 0, 1);
    check_eq("release_npc8", 64'(npc_out), 64'h8);
    step(1, 32'hC, 32'hC, 1, 0, 1);
    check_eq("release_npcC", 64'(npc_out), 64'hC);
    step(0, 0, 0, 1, 0, 1);

    // Flush with skid full and a beat offered.
    step(1, 32'h11, 32'h14, 0, 0, 1);
    step(1, 32'h22, 32'h18, 0, 0, 1);
    step(1, 32'h33, 32'h20, 0, 1, 1);
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    check_eq("flush_instr", 64'(instr_out), 64'(Nop));
    check_eq("flush_npc", 64'(npc_out), 64'd0);
    check_eq("flush_in_ready", 64'(in_ready), 64'd1);
    step(0, 0, 0, 1, 0, 1);
    check_eq("flush_dropped", 64'(out_valid), 64'd0);

    // Reset mid-stall with both entries full.
    step(1, 32'h44, 32'h24, 0, 0, 1);
    step(1, 32'h55, 32'h28, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 32'h66, 32'h2C, 0, 0, 1);
    step(1, 32'h66, 32'h2C, 0, 1, 0);
    check_eq("rst2_valid", 64'(out_valid), 64'd0);
    check_eq("rst2_instr", 64'(instr_out), 64'(Nop));
    check_eq("rst2_in_ready", 64'(in_ready), 64'd1);
`ifdef STALL_CNT_EN
    check_eq("rst2_stall", 64'(stall_cnt), 64'd0);
`endif

    // Randomized traffic; a refused beat is re-offered unchanged.
    hold = 1'b0; v = 1'b0; ins = '0; pc = '0; next_pc = 32'h100;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        v   = ($urandom_range(0, 9) < 7);
        ins = $urandom;
        pc  = next_pc;
      end
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 99) < 3);
      rn   = ($urandom_range(0, 199) != 0);
      step(v, ins, pc, ordy, fl, rn);
      if (last_acc) next_pc = next_pc + 32'd4;
      hold = v && !last_acc && !fl && rn;
    end

`ifdef STALL_CNT_EN
    // Saturation: preload the counter just below the top, then stall.
    step(1, 32'h77, 32'h30, 0, 0, 1);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_stall = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
    check_eq("stall_sat", 64'(stall_cnt), 64'hFFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
